// File: rtl/multi_channel_pulse_sequencer.sv
// multi_channel_pulse_sequencer: steered multi-channel TX bursts followed by delay/demod/delay/retransmit phases
module multi_channel_pulse_sequencer #(
  parameter int NUM_TX = 4,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 4,
  parameter int DLY_W  = 5
) (
  input  logic                    coreClock,
  input  logic                    RESET_N,
  input  logic                    ENABLE,
  input  logic                    SINGLE_SHOT,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [DIV_W-1:0]        TX_HALF_DIV,
  input  logic [7:0]              BURST_CYC,
  input  logic [NUM_TX*DLY_W-1:0] CH_DELAY,
  input  logic [NUM_TX-1:0]       CH_MASK,
  input  logic [CNT_W-1:0]        DELAY1_LEN,
  input  logic [CNT_W-1:0]        DEMOD_LEN,
  input  logic [CNT_W-1:0]        DELAY2_LEN,
  input  logic [DIV_W-1:0]        RX_HALF_DIV,
  output logic [NUM_TX-1:0]       TX_P,
  output logic [NUM_TX-1:0]       TX_N,
  output logic                    RX_CLK,
  output logic                    DEMOD_ON,
  output logic                    RETRANSMIT,
  output logic                    BUSY,
  output logic [CNT_W-1:0]        SEQ_COUNT
);
  typedef enum logic [2:0] {IDLE, BURST, DELAY1, DEMOD, DELAY2, RETX} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] d1_q, d1_d, dm_q, dm_d, d2_q, d2_d, cnt_q, cnt_d, seq_q, seq_d;
  logic [NUM_TX-1:0][DLY_W-1:0] wait_q, wait_d;
  logic [NUM_TX-1:0][DIV_W-1:0] hc_q, hc_d;
  logic [NUM_TX-1:0][8:0] hl_q, hl_d;
  logic [NUM_TX-1:0] p_q, p_d, n_q, n_d, ch_last;
  logic [DIV_W-1:0] rxc_q, rxc_d;
  logic rx_q, demod_q, retx_q, busy_q;
  logic go, reload, load, burst_end;
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction
  assign go = SINGLE_SHOT ? START : ENABLE;
  assign reload = !SINGLE_SHOT && ENABLE;
  assign load = !ABORT && ((state_q == IDLE && go) || (state_q == RETX && reload));
  // A channel is on its final BURST cycle when idle-done or in the last cycle of its last half-period
  always_comb begin
    for (int i = 0; i < NUM_TX; i++)
      ch_last[i] = (wait_q[i] == '0 && !p_q[i] && !n_q[i]) ||
                   ((p_q[i] || n_q[i]) && hc_q[i] == half_q && hl_q[i] == '0);
  end
  assign burst_end = &ch_last;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    seq_d = seq_q;
    half_d = load ? TX_HALF_DIV : half_q;
    d1_d = load ? DELAY1_LEN : d1_q;
    dm_d = load ? DEMOD_LEN : dm_q;
    d2_d = load ? DELAY2_LEN : d2_q;
    case (state_q)
      IDLE: state_d = go ? BURST : IDLE;
      BURST: if (burst_end) begin
        state_d = DELAY1;
        cnt_d = len_m1(d1_q);
      end
      DELAY1: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DEMOD;
          cnt_d = len_m1(dm_q);
        end
      end
      DEMOD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DELAY2;
          cnt_d = len_m1(d2_q);
        end
      end
      DELAY2: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = RETX;
      end
      RETX: begin
        seq_d = seq_q + 1'b1;
        state_d = reload ? BURST : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ABORT) begin
      state_d = IDLE;
      seq_d = seq_q;
    end
  end
  // Per-channel counters are loaded straight from the inputs on the start edge and act as the channel shadow
  always_comb begin
    wait_d = wait_q;
    hc_d = hc_q;
    hl_d = hl_q;
    p_d = '0;
    n_d = '0;
    for (int i = 0; i < NUM_TX; i++) begin
      if (load) begin
        wait_d[i] = (CH_MASK[i] && BURST_CYC != 8'd0) ? CH_DELAY[i*DLY_W +: DLY_W] : '0;
        hc_d[i] = '0;
        hl_d[i] = {BURST_CYC, 1'b0} - 9'd1;
        p_d[i] = CH_MASK[i] && BURST_CYC != 8'd0 && CH_DELAY[i*DLY_W +: DLY_W] == '0;
      end else if (state_q == BURST && !burst_end && !ABORT) begin
        if (wait_q[i] > DLY_W'(1)) begin
          wait_d[i] = wait_q[i] - 1'b1;
        end else if (wait_q[i] == DLY_W'(1)) begin
          wait_d[i] = '0;
          p_d[i] = 1'b1;
        end else if (p_q[i] || n_q[i]) begin
          if (hc_q[i] != half_q) begin
            hc_d[i] = hc_q[i] + 1'b1;
            p_d[i] = p_q[i];
            n_d[i] = n_q[i];
          end else if (hl_q[i] != '0) begin
            hc_d[i] = '0;
            hl_d[i] = hl_q[i] - 1'b1;
            p_d[i] = n_q[i];
            n_d[i] = p_q[i];
          end
        end
      end
    end
  end
  always_comb begin
    rxc_d = (rxc_q == '0) ? RX_HALF_DIV : rxc_q - 1'b1;
  end
  always_ff @(posedge coreClock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      half_q <= '0;
      d1_q <= '0;
      dm_q <= '0;
      d2_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
      wait_q <= '0;
      hc_q <= '0;
      hl_q <= '0;
      p_q <= '0;
      n_q <= '0;
      rxc_q <= '0;
      rx_q <= 1'b0;
      demod_q <= 1'b0;
      retx_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      d1_q <= d1_d;
      dm_q <= dm_d;
      d2_q <= d2_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      wait_q <= wait_d;
      hc_q <= hc_d;
      hl_q <= hl_d;
      p_q <= p_d;
      n_q <= n_d;
      rxc_q <= rxc_d;
      rx_q <= rx_q ^ (rxc_q == '0);
      demod_q <= state_d == DEMOD;
      retx_q <= state_d == RETX;
      busy_q <= state_d != IDLE;
    end
  end
  assign TX_P = p_q;
  assign TX_N = n_q;
  assign RX_CLK = rx_q;
  assign DEMOD_ON = demod_q;
  assign RETRANSMIT = retx_q;
  assign BUSY = busy_q;
  assign SEQ_COUNT = seq_q;
endmodule
